// File: rtl/tube_pkg.sv
// Shared constants and state encoding for the 74HC595-driven six-digit tube scanner.
package tube_pkg;

  localparam int DIGIT_COUNT = 6;
  localparam int WORD_BITS   = 14;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    SHIFT_LOW  = 3'd2,
    SHIFT_HIGH = 3'd3,
    LATCH      = 3'd4,
    HOLD       = 3'd5
  } state_t;

  // One-hot, active-high digit select for the low byte of the shifted word.
  function automatic logic [DIGIT_COUNT-1:0] digit_sel(input logic [2:0] idx);
    return DIGIT_COUNT'(1) << idx;
  endfunction

endpackage

// File: rtl/hc595_shifter.sv
// Serialises one 14-bit word MSB first into a 74HC595 chain, then pulses the
// storage clock. done is high on the last LATCH cycle.
module hc595_shifter
  import tube_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 system_clock,
  input  logic                 system_reset,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] word,
  output logic                 ds,
  output logic                 shcp,
  output logic                 stcp,
  output logic                 done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t               phase;
  logic [DW-1:0]        div_cnt;
  logic [3:0]           bit_cnt;
  logic [WORD_BITS-1:0] sreg;
  logic                 phase_end;

  assign phase_end = (div_cnt == DW'(CLK_DIV - 1));
  assign done      = (phase == LATCH) && phase_end;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      phase   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
      ds      <= 1'b0;
      shcp    <= 1'b0;
      stcp    <= 1'b0;
    end else begin
      div_cnt <= (phase == IDLE || phase_end) ? '0 : div_cnt + DW'(1);
      unique case (phase)
        IDLE: begin
          if (start) begin
            phase   <= SHIFT_LOW;
            sreg    <= word;
            ds      <= word[WORD_BITS-1];
            bit_cnt <= '0;
          end
        end
        SHIFT_LOW: begin
          if (phase_end) begin
            phase <= SHIFT_HIGH;
            shcp  <= 1'b1;
          end
        end
        SHIFT_HIGH: begin
          if (phase_end) begin
            shcp <= 1'b0;
            if (bit_cnt == 4'(WORD_BITS - 1)) begin
              phase <= LATCH;
              stcp  <= 1'b1;
              ds    <= 1'b0;
            end else begin
              phase   <= SHIFT_LOW;
              bit_cnt <= bit_cnt + 4'd1;
              sreg    <= {sreg[WORD_BITS-2:0], 1'b0};
              ds      <= sreg[WORD_BITS-2];
            end
          end
        end
        LATCH: begin
          if (phase_end) begin
            phase <= IDLE;
            stcp  <= 1'b0;
          end
        end
        default: phase <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dynamic_tube_scanner.sv
// Six-digit multiplexed tube scanner: digit buffer plus slot sequencer feeding
// an hc595_shifter; each slot lasts SCAN_CYCLES clocks from LOAD to LOAD.
module dynamic_tube_scanner
  import tube_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int SCAN_CYCLES = 50000
) (
  input  logic       system_clock,
  input  logic       system_reset,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe,
  output logic       busy,
  output logic       frame_done
);

  localparam int SW = $clog2(SCAN_CYCLES);

  state_t               state;
  logic [7:0]           digit_buf [DIGIT_COUNT];
  logic [2:0]           idx;
  logic [SW-1:0]        scan_cnt;
  logic                 shift_done;
  logic [WORD_BITS-1:0] word;

  assign word = {digit_buf[idx], digit_sel(idx)};
  assign busy = (state != IDLE);

  // NOTE: the buffer is a small register file that must read 0x00 after
  // reset, so it is reset explicitly rather than inferred as a RAM.
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      for (int i = 0; i < DIGIT_COUNT; i++) digit_buf[i] <= 8'h00;
    end else if (wr_en && wr_addr < 3'(DIGIT_COUNT)) begin
      digit_buf[wr_addr] <= wr_data;
    end
  end

  hc595_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .system_clock (system_clock),
    .system_reset (system_reset),
    .start        (state == LOAD),
    .word         (word),
    .ds           (ds),
    .shcp         (shcp),
    .stcp         (stcp),
    .done         (shift_done)
  );

  // The sequencer parks in SHIFT_LOW for the whole transfer; the shifter owns
  // the SHIFT_LOW/SHIFT_HIGH/LATCH sub-phases. scan_cnt counts the LOAD cycle
  // as slot cycle 0, so LOAD-to-LOAD spacing is exactly SCAN_CYCLES.
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      state      <= IDLE;
      idx        <= '0;
      scan_cnt   <= '0;
      oe         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      scan_cnt   <= scan_cnt + SW'(1);
      unique case (state)
        IDLE: begin
          scan_cnt <= '0;
          oe       <= 1'b1;
          if (enable) state <= LOAD;
        end
        LOAD: state <= SHIFT_LOW;
        SHIFT_LOW: begin
          if (shift_done) begin
            state <= HOLD;
            oe    <= 1'b0;
          end
        end
        HOLD: begin
          if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
            scan_cnt   <= '0;
            idx        <= (idx == 3'(DIGIT_COUNT - 1)) ? 3'd0 : idx + 3'd1;
            frame_done <= (idx == 3'(DIGIT_COUNT - 1));
            if (enable) begin
              state <= LOAD;
            end else begin
              state <= IDLE;
              oe    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dynamic_tube_scanner.sv
// Scoreboard bench: expected latched words are queued by the stimulus; a monitor
// rebuilds each word from ds on shcp rising edges and compares on stcp.
module tb_dynamic_tube_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       ds, shcp, stcp, oe, busy, frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [13:0] exp_q [$];
  int          rise_q [$];
  int          fd_q [$];
  int          overlap_cnt = 0;

  dynamic_tube_scanner #(.CLK_DIV(2), .SCAN_CYCLES(100)) dut (
    .system_clock (clk),
    .system_reset (rst),
    .enable       (enable),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .ds           (ds),
    .shcp         (shcp),
    .stcp         (stcp),
    .oe           (oe),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_busy(output int t);
    int n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!busy) fail_now("load_timeout");
    t = cyc;
  endtask

  task automatic write_buf(input logic [2:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Monitor: reassemble each shifted word and score it when the latch pulse rises.
  logic [13:0] acc = '0;
  int          nbits = 0;
  logic        prev_shcp = 1'b0;
  logic        prev_stcp = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      acc   = '0;
      nbits = 0;
    end else begin
      if (shcp && stcp) overlap_cnt++;
      if (shcp && !prev_shcp) begin
        acc = {acc[12:0], ds};
        nbits++;
      end
      if (stcp && !prev_stcp) begin
        rise_q.push_back(cyc);
        check("shcp_edges_per_word", nbits, 14);
        if (exp_q.size() == 0) fail_now("unexpected_latch");
        else check("latched_word", acc, exp_q.pop_front());
        nbits = 0;
      end
      if (frame_done) fd_q.push_back(cyc);
    end
    prev_shcp = shcp;
    prev_stcp = stcp;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int   l0, l2, l3;
    logic act;
    logic [13:0] words [13] = '{
      14'h3001, 14'h0002, 14'h0004, 14'h0008, 14'h0010, 14'h0020,
      14'h3001, 14'h0002, 14'h2904, 14'h0008, 14'h0010, 14'h0020,
      14'h3001
    };
    logic stcp_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic oe_exp   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_ds", ds, 0);
    check("rst_shcp", shcp, 0);
    check("rst_stcp", stcp, 0);
    check("rst_oe", oe, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;

    act = 1'b0;
    repeat (200) begin
      @(negedge clk);
      act = act | ds | shcp | stcp | busy | ~oe | frame_done;
    end
    check("idle_quiet", act, 0);

    // Two full frames plus one slot; digit 2 changes to 0xA4 during frame 1.
    write_buf(3'd0, 8'hC0);
    foreach (words[i]) exp_q.push_back(words[i]);
    enable = 1'b1;
    wait_busy(l0);

    for (int k = 0; k < 4; k++) begin
      wait_cyc(l0 + 56 + k);
      check("stcp_timing", stcp, stcp_exp[k]);
      check("oe_timing", oe, oe_exp[k]);
    end

    wait_cyc(l0 + 210);
    write_buf(3'd2, 8'hA4);
    wait_cyc(l0 + 220);
    write_buf(3'd7, 8'hFF);

    wait_cyc(l0 + 1210);
    enable = 1'b0;
    wait_cyc(l0 + 1299);
    check("drop_busy_last", busy, 1);
    check("drop_oe_last", oe, 0);
    wait_cyc(l0 + 1300);
    check("drop_busy_idle", busy, 0);
    check("drop_oe_idle", oe, 1);

    wait_cyc(l0 + 1400);
    check("latch_count", rise_q.size(), 13);
    if (rise_q.size() >= 13) begin
      check("first_latch_cycle", rise_q[0], l0 + 57);
      for (int i = 0; i < 12; i++) check("load_spacing", rise_q[i+1] - rise_q[i], 100);
    end
    check("frame_done_count", fd_q.size(), 2);
    if (fd_q.size() >= 2) begin
      check("frame_done_first", fd_q[0], l0 + 600);
      check("frame_done_period", fd_q[1] - fd_q[0], 600);
    end

    // Reset while shcp is high on the first bit of digit 1 (word MSB = 1).
    write_buf(3'd1, 8'h80);
    enable = 1'b1;
    wait_busy(l2);
    wait_cyc(l2 + 3);
    check("pre_reset_shcp", shcp, 1);
    check("pre_reset_ds", ds, 1);
    rst = 1'b1;
    enable = 1'b0;
    wait_cyc(l2 + 4);
    check("mid_rst_ds", ds, 0);
    check("mid_rst_shcp", shcp, 0);
    check("mid_rst_stcp", stcp, 0);
    check("mid_rst_oe", oe, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_done", frame_done, 0);
    wait_cyc(l2 + 6);
    rst = 1'b0;
    wait_cyc(l2 + 100);
    check("no_latch_after_abort", rise_q.size(), 13);

    // After reset the buffer is cleared and the scan restarts at digit 0.
    exp_q.push_back(14'h0001);
    enable = 1'b1;
    wait_busy(l3);
    wait_cyc(l3 + 20);
    enable = 1'b0;
    wait_cyc(l3 + 101);
    check("post_reset_idle", busy, 0);
    check("post_reset_latch_count", rise_q.size(), 14);
    check("scoreboard_drained", exp_q.size(), 0);
    check("shcp_stcp_overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
